tpu_instr_sequencer: RTL

Host-side instruction issuer for the Mini TPU and the initiator of the 16-bit instruction stream consumed by the control unit. It takes a 32-byte operand stream, emits LOAD instructions, then START, waits a fixed compute window, then STOP. It then issues 16 STORE instructions and returns each captured array result to the host over a valid/ready port.

---
 rtl/tpu_pkg.sv | 33 +++
 rtl/tpu_instr_encoder.sv | 27 ++
 rtl/tpu_instr_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the Mini TPU host-side instruction path: opcodes, instruction
// field positions, operand memory selectors and the sequencer state encoding.
package tpu_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned INSTR_WIDTH = 16;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    localparam int unsigned OPC_LSB     = 14;
    localparam int unsigned MEM_SEL_BIT = 13;
    localparam int unsigned ROW_LSB     = 10;
    localparam int unsigned COL_LSB     = 8;
    localparam int unsigned IMM_LSB     = 0;

    localparam logic MEM_A = 1'b0;
    localparam logic MEM_B = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStartI,
        StCompute,
        StStopI,
        StStoreI,
        StCapture,
        StResult
    } seq_state_e;

endpackage

// File: rtl/tpu_instr_encoder.sv
// Packs opcode and operand fields into the 16-bit control-unit instruction word.
module tpu_instr_encoder
    import tpu_pkg::*;
(
    input  logic [1:0]  opcode,
    input  logic        mem_sel,
    input  logic [1:0]  row,
    input  logic [1:0]  col,
    input  logic [7:0]  imm,
    output logic [15:0] instr
);

    logic is_load;

    assign is_load = (opcode == OP_LOAD);

    always_comb begin
        instr = '0;
        instr[OPC_LSB +: 2] = opcode;
        // mem_sel and imm only carry meaning for LOAD
        instr[MEM_SEL_BIT]  = is_load ? mem_sel : 1'b0;
        instr[ROW_LSB +: 2] = row;
        instr[COL_LSB +: 2] = col;
        instr[IMM_LSB +: 8] = is_load ? imm : 8'h00;
    end

endmodule

// File: rtl/tpu_instr_sequencer.sv
// Host-side issuer: LOADs 32 operand bytes, START, compute wait, STOP, then 16 STORE/readback
// pairs. Define TPU_SEQ_PERF_EN to add the job_cycles performance counter port.
module tpu_instr_sequencer #(
    parameter int unsigned DATA_WIDTH     = tpu_pkg::DATA_WIDTH,
    parameter int unsigned RES_WIDTH      = 16,
    parameter int unsigned COMPUTE_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [15:0]           instr,
    input  logic [RES_WIDTH-1:0]  result_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RES_WIDTH-1:0]  out_data,
    output logic                  busy,
    output logic                  done
`ifdef TPU_SEQ_PERF_EN
    ,
    output logic [15:0]           job_cycles
`endif
);

    import tpu_pkg::*;

    localparam int unsigned CntW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

    seq_state_e           state_q, state_d;
    logic [4:0]           idx_q, idx_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 issued_q, issued_d;
    logic [15:0]          instr_q, instr_d;
    logic                 instr_valid_q, instr_valid_d;
    logic                 out_valid_q, out_valid_d;
    logic [RES_WIDTH-1:0] out_data_q, out_data_d;
    logic                 done_q, done_d;

    logic       instr_accept;
    logic       reg_free;
    logic       load_instr;
    logic [1:0] enc_op;
    logic [4:0] enc_idx;
    logic [15:0] enc_instr;

    assign instr_accept = instr_valid_q && instr_ready;
    assign reg_free     = !instr_valid_q || instr_ready;

    // RESULT pre-encodes the next STORE so it can load on the out handshake
    assign enc_idx = (state_q == StLoad)   ? idx_q :
                     (state_q == StResult) ? idx_q + 5'd1 : 5'd0;
    assign enc_op  = (state_q == StLoad)    ? OP_LOAD  :
                     (state_q == StStartI)  ? OP_START :
                     (state_q == StCompute) ? OP_STOP  : OP_STORE;

    tpu_instr_encoder u_encoder (
        .opcode  (enc_op),
        .mem_sel (enc_idx[4]),
        .row     (enc_idx[3:2]),
        .col     (enc_idx[1:0]),
        .imm     (8'(in_data)),
        .instr   (enc_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            cnt_q         <= '0;
            issued_q      <= 1'b0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            issued_q      <= issued_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        issued_d      = issued_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q && !instr_accept;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        done_d        = 1'b0;
        load_instr    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    state_d = StLoad;
                    idx_d   = '0;
                end
            end
            StLoad: begin
                if (in_valid && reg_free) begin
                    load_instr = 1'b1;
                    if (idx_q == 5'd31) begin
                        state_d  = StStartI;
                        idx_d    = '0;
                        issued_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            StStartI: begin
                if (!issued_q) begin
                    if (reg_free) begin
                        load_instr = 1'b1;
                        issued_d   = 1'b1;
                    end
                end else if (instr_accept) begin
                    state_d  = StCompute;
                    cnt_d    = '0;
                    issued_d = 1'b0;
                end
            end
            StCompute: begin
                // STOP is loaded on the last wait cycle so it appears exactly on time
                if (cnt_q == CntW'(COMPUTE_CYCLES - 1)) begin
                    load_instr = 1'b1;
                    state_d    = StStopI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStopI: begin
                if (instr_accept) begin
                    load_instr = 1'b1;
                    idx_d      = '0;
                    state_d    = StStoreI;
                end
            end
            StStoreI: begin
                if (instr_accept) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                out_data_d  = result_in;
                out_valid_d = 1'b1;
                state_d     = StResult;
            end
            StResult: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == 5'd15) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        load_instr = 1'b1;
                        idx_d      = idx_q + 5'd1;
                        state_d    = StStoreI;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_instr) begin
            instr_d       = enc_instr;
            instr_valid_d = 1'b1;
        end
    end

    always_comb begin
        in_ready    = (state_q == StLoad) && reg_free;
        busy        = (state_q != StIdle);
        instr       = instr_q;
        instr_valid = instr_valid_q;
        out_valid   = out_valid_q;
        out_data    = out_data_q;
        done        = done_q;
    end

`ifdef TPU_SEQ_PERF_EN
    logic [15:0] job_cycles_q;

    // Counts the go cycle through the done cycle inclusive, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_cycles_q <= '0;
        end else if (state_q == StIdle && go) begin
            job_cycles_q <= 16'd1;
        end else if ((busy || done_q) && job_cycles_q != 16'hFFFF) begin
            job_cycles_q <= job_cycles_q + 16'd1;
        end
    end

    assign job_cycles = job_cycles_q;
`endif

endmodule
